// File: rtl/noc_pkg.sv
// Shared NoC packet format: field offsets, total packet width and drop-counter width.
package noc_pkg;

    // The payload always starts at bit 0 of a packet.
    localparam int PAYLOAD_LSB = 0;

    // Width of the saturating drop counter reported by endpoints.
    localparam int DROP_CNT_W = 16;

    // dest_x sits directly above the payload.
    function automatic int destXLsb(input int dataWidth);
        return PAYLOAD_LSB + dataWidth;
    endfunction

    // dest_y sits directly above dest_x and forms the packet MSBs.
    function automatic int destYLsb(input int dataWidth, input int xSize);
        return PAYLOAD_LSB + dataWidth + xSize;
    endfunction

    // Full packet width: {dest_y, dest_x, payload}.
    function automatic int totalWidth(input int dataWidth, input int xSize, input int ySize);
        return dataWidth + xSize + ySize;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; storage clears on reset so dout never carries X.
module noc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             doPush;
    logic             doPop;

    assign empty = (wrPtr_q == rdPtr_q);
    assign full  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
    assign dout  = mem_q[rdPtr_q[AW-1:0]];

    // A push into a full FIFO is honoured only when the head leaves in the same cycle.
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);

    // Pointer advance and storage write; everything clears asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q[AW-1:0]] <= din;
                wrPtr_q <= wrPtr_q + PTR_ONE;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/noc_pe_interface.sv
// PE-side NoC endpoint: packs and injects local messages, buffers deliveries, flags drops and misroutes.
module noc_pe_interface
    import noc_pkg::*;
#(
    parameter int X          = 4,
    parameter int Y          = 4,
    parameter int data_width = 256,
    parameter int x_size     = 2,
    parameter int y_size     = 2,
    parameter int x_coord    = 0,
    parameter int y_coord    = 0,
    parameter int TX_DEPTH   = 4,
    parameter int RX_DEPTH   = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_valid_tx,
    input  logic [x_size-1:0]                      i_dest_x,
    input  logic [y_size-1:0]                      i_dest_y,
    input  logic [data_width-1:0]                  i_data_tx,
    output logic                                   o_ready_tx,
    output logic                                   o_valid_noc,
    output logic [x_size+y_size+data_width-1:0]    o_data_noc,
    input  logic                                   i_ready_noc,
    input  logic                                   i_valid_noc,
    input  logic [x_size+y_size+data_width-1:0]    i_data_noc,
    output logic                                   o_valid_rx,
    output logic [data_width-1:0]                  o_data_rx,
    input  logic                                   i_ready_rx,
    output logic                                   o_rx_overflow,
    output logic                                   o_misroute,
    output logic [DROP_CNT_W-1:0]                  o_drop_count
);

    localparam int TW     = totalWidth(data_width, x_size, y_size);
    localparam int DX_LSB = destXLsb(data_width);
    localparam int DY_LSB = destYLsb(data_width, x_size);

    logic                  txFull;
    logic                  txEmpty;
    logic                  txPush;
    logic                  txPop;
    logic                  rxFull;
    logic                  rxEmpty;
    logic                  rxPush;
    logic                  rxPop;
    logic                  readyEn_q;
    logic [x_size-1:0]     arrX;
    logic [y_size-1:0]     arrY;
    logic                  destMatch;
    logic                  dropNow;
    logic                  overflow_q,  overflow_d;
    logic                  misroute_q,  misroute_d;
    logic [DROP_CNT_W-1:0] dropCount_q, dropCount_d;

    // ---------------- transmit path ----------------
    assign o_ready_tx  = readyEn_q & ~txFull;
    assign o_valid_noc = ~txEmpty;
    assign txPush      = i_valid_tx & o_ready_tx;
    assign txPop       = o_valid_noc & i_ready_noc;

    noc_sync_fifo #(
        .WIDTH (TW),
        .DEPTH (TX_DEPTH)
    ) uTxFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (txPush),
        .pop   (txPop),
        .din   ({i_dest_y, i_dest_x, i_data_tx}),
        .dout  (o_data_noc),
        .full  (txFull),
        .empty (txEmpty)
    );

    // Holds o_ready_tx low while reset is asserted; rises at the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readyEn_q <= 1'b0;
        end else begin
            readyEn_q <= 1'b1;
        end
    end

    // ---------------- receive path ----------------
    assign arrX = i_data_noc[DX_LSB +: x_size];
    assign arrY = i_data_noc[DY_LSB +: y_size];

    // A destination outside the mesh can never match this endpoint.
    assign destMatch = (arrX == x_coord[x_size-1:0]) && (arrY == y_coord[y_size-1:0])
                    && ({1'b0, arrX} < X[x_size:0]) && ({1'b0, arrY} < Y[y_size:0]);

    assign o_valid_rx = ~rxEmpty;
    assign rxPop      = o_valid_rx & i_ready_rx;
    assign rxPush     = i_valid_noc & destMatch & (~rxFull | rxPop);
    assign dropNow    = i_valid_noc & destMatch & rxFull & ~rxPop;

    noc_sync_fifo #(
        .WIDTH (data_width),
        .DEPTH (RX_DEPTH)
    ) uRxFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rxPush),
        .pop   (rxPop),
        .din   (i_data_noc[PAYLOAD_LSB +: data_width]),
        .dout  (o_data_rx),
        .full  (rxFull),
        .empty (rxEmpty)
    );

    // Sticky flags and saturating drop counter next-state.
    always_comb begin
        overflow_d  = overflow_q;
        misroute_d  = misroute_q;
        dropCount_d = dropCount_q;
        if (i_valid_noc && !destMatch) begin
            misroute_d = 1'b1;
        end
        if (dropNow) begin
            overflow_d = 1'b1;
            if (dropCount_q != {DROP_CNT_W{1'b1}}) begin
                dropCount_d = dropCount_q + DROP_CNT_W'(1);
            end
        end
    end

    // Status registers; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            misroute_q  <= 1'b0;
            dropCount_q <= '0;
        end else begin
            overflow_q  <= overflow_d;
            misroute_q  <= misroute_d;
            dropCount_q <= dropCount_d;
        end
    end

    assign o_rx_overflow = overflow_q;
    assign o_misroute    = misroute_q;
    assign o_drop_count  = dropCount_q;

endmodule

// File: doc/noc_pe_interface.md
# noc_pe_interface

PE-side endpoint of the mesh NoC: packs local messages into NoC packets and injects them into the attached switch's PE port, and captures packets the switch delivers to this PE. One instance sits between each processing element and its switch at coordinate (x_coord, y_coord). The switch's PE output has no backpressure, so the receive side buffers arrivals and drops them on overflow, reporting each drop.

## Interface
- X, 4, mesh columns
- Y, 4, mesh rows
- data_width, 256, payload bits
- x_size, 2, destination-x field width
- y_size, 2, destination-y field width
- x_coord, 0, this PE's column
- y_coord, 0, this PE's row
- TX_DEPTH, 4, transmit FIFO entries (power of 2, ≥2)
- RX_DEPTH, 4, receive FIFO entries (power of 2, ≥2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- i_valid_tx  in  1  local message valid
- i_dest_x  in  x_size  destination column
- i_dest_y  in  y_size  destination row
- i_data_tx  in  data_width  message payload
- o_ready_tx  out  1  transmit FIFO can accept a message
- o_valid_noc  out  1  packet valid toward the switch PE input
- o_data_noc  out  x_size+y_size+data_width  packet toward the switch
- i_ready_noc  in  1  switch accepts the packet
- i_valid_noc  in  1  packet delivered by the switch
- i_data_noc  in  x_size+y_size+data_width  delivered packet
- o_valid_rx  out  1  received payload valid
- o_data_rx  out  data_width  received payload
- i_ready_rx  in  1  local consumer takes the payload
- o_rx_overflow  out  1  sticky: at least one arrival was dropped
- o_misroute  out  1  sticky: an arrival carried a destination other than (x_coord, y_coord)
- o_drop_count  out  16  total dropped arrivals, saturating

## Operation
- Packet format, MSB to LSB: {dest_y, dest_x, payload}. The payload occupies [data_width-1:0], dest_x occupies the next x_size bits, and dest_y occupies the top y_size bits.
- TX: push {i_dest_y, i_dest_x, i_data_tx} when i_valid_tx & o_ready_tx. The FIFO head drives o_data_noc. o_valid_noc = TX FIFO not empty. Pop on o_valid_noc & i_ready_noc.
- o_ready_tx = !tx_full. A push and a pop in the same cycle are both honoured, and the occupancy stays unchanged.
- TX rule: o_valid_noc and o_data_noc stay stable until accepted. The block never withdraws a presented packet.
- RX: when i_valid_noc rises, compare the packet's destination fields with the block's coordinates.
  - Mismatch: set o_misroute and discard the packet. The drop counter is not affected.
  - Match, FIFO has room, or FIFO full with a pop (o_valid_rx & i_ready_rx) in the same cycle: push the payload.
  - Match, FIFO full, no pop: drop the packet, set o_rx_overflow, and increment o_drop_count, which saturates at 16'hFFFF.
- o_valid_rx = RX FIFO not empty. o_data_rx = head payload. Pop on o_valid_rx & i_ready_rx.
- Sticky flags clear only on rst.

## Timing
- Reset values: o_ready_tx=0 while rst is asserted and 1 in the first cycle after release. o_valid_noc=0, o_valid_rx=0, o_rx_overflow=0, o_misroute=0, o_drop_count=0. o_data_noc and o_data_rx are don't-care but must not be X-propagating, so FIFO storage is reset to 0.
- TX latency: a push at edge N gives o_valid_noc=1 after edge N with the packet on o_data_noc. This is 1 cycle from the i_valid_tx sample.
- RX latency: i_valid_noc sampled at edge N gives o_valid_rx=1 after edge N. This is 1 cycle.
- o_ready_tx, o_valid_noc and o_valid_rx are derived from registered pointers/counts only. There is no combinational path from i_ready_noc to o_ready_tx, or from i_valid_noc to o_valid_rx.
- Full throughput: one TX and one RX transfer per cycle is sustained indefinitely when the far side is always ready.
- Pointer wrap: pointers are log2(DEPTH)+1 bits. full = pointers equal in index bits with differing MSB. empty = pointers fully equal.
- rst mid-operation: both FIFOs empty immediately (asynchronous reset), in-flight packets are lost, and counters and flags clear.

## Structure
- Shared package/header noc_pkg holds the packet field offsets (payload LSB, dest_x LSB, dest_y LSB), the total_width expression, and the drop-counter width constant 16, so switches and endpoints agree on the format.
- One sub-module, noc_sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty), instantiated twice: for TX with WIDTH=total_width and for RX with WIDTH=data_width.
- The top level contains packing, destination check, drop/overflow logic and the saturating counter.

## Test plan
- After rst, push 4 messages (dest (1,2), payloads 0xA0..0xA3) with i_ready_noc=0. Required: o_ready_tx falls after the 4th push. o_data_noc holds {2'd2,2'd1,0xA0} stable. Raising i_ready_noc drains the packets in order, one per cycle.
- i_valid_tx and the TX pop both active every cycle while TX holds 2 entries. Required: occupancy stays at 2 and o_ready_tx stays 1.
- Instance at (0,0), i_ready_rx=0, 6 matching arrivals. Required: 4 are buffered, o_drop_count=2, o_rx_overflow=1. Then drain and check payloads 1..4 in order.
- RX FIFO full with an arrival and i_ready_rx=1 in the same cycle. Required: no drop, and o_drop_count is unchanged.
- Arrival with dest (3,1) at instance (0,0). Required: o_misroute=1, o_valid_rx stays 0, and o_drop_count stays 0.
- Assert rst while both FIFOs are partially full and the counter is 5. Required: all outputs return to reset values asynchronously, and normal traffic resumes afterwards.
